reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 78 +++++++
 tb/tb_reg_file_mp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with x0 hardwired to zero, write-to-read
// bypass, a per-register pending-write scoreboard and a duplicate-write-address flag.
module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic                wr_conflict
);
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic                       conflict_q, conflict_d;
  logic [AW-1:0]              ra, wa, wb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      conflict_q <= conflict_d;
    end
  end
  // Ascending port order lets the highest-index write win; alloc is applied last
  // so a same-cycle alloc leaves the new producer pending.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    conflict_d = 1'b0;
    wa = '0;
    wb = '0;
    for (int w = 0; w < NWR; w++) begin
      wa = wr_addr[w*AW +: AW];
      if (wr_en[w] && wa != '0) begin
        regs_d[wa] = wr_data[w*XLEN +: XLEN];
        busy_d[wa] = 1'b0;
      end
      for (int b = w + 1; b < NWR; b++) begin
        wb = wr_addr[b*AW +: AW];
        if (wr_en[w] && wr_en[b] && wa == wb && wa != '0) conflict_d = 1'b1;
      end
    end
    if (alloc_en && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      rd_data[i*XLEN +: XLEN] = regs_q[ra];
      rd_busy[i] = busy_q[ra];
      for (int w = 0; w < NWR; w++) begin
        if (BYPASS != 0 && wr_en[w] && wr_addr[w*AW +: AW] == ra && ra != '0) begin
          rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          rd_busy[i] = 1'b0;
        end
      end
    end
  end
  assign busy_vec = busy_q;
  assign wr_conflict = conflict_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed vector table plus reset sequences, run on a bypassing
// and a non-bypassing instance driven by the same stimulus.
module tb_reg_file_mp;
  logic        clk, rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [31:0] busy_vec, busy_vec_nb;
  logic        wr_conflict, wr_conflict_nb;
  int n_chk = 0;
  int n_fail = 0;

  reg_file_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );
  reg_file_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_vec(busy_vec_nb), .wr_conflict(wr_conflict_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ae;
    logic [4:0]  aa, ra0, ra1;
    logic [31:0] d0, d1, nb0;
    logic [1:0]  rb;
    logic        nbb;
    logic [31:0] bv;
    logic        cf;
  } vec_t;
  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 32'h22, 2'b00, 1'b0, 32'h0, 1'b1};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 32'h22, 2'b00, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 32'h0, 2'b11, 1'b1, 32'h8, 1'b0};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7, 32'h0, 32'h22, 32'h0, 2'b01, 1'b1, 32'h8, 1'b0};
    vecs[8]  = '{2'b10, 5'd0, 5'd3, 32'h0, 32'h1234, 1'b0, 5'd0, 5'd3, 5'd3, 32'h1234, 32'h1234, 32'h0, 2'b00, 1'b1, 32'h8, 1'b0};
    vecs[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h1234, 32'h0, 32'h1234, 2'b00, 1'b0, 32'h0, 1'b0};
    vecs[10] = '{2'b01, 5'd3, 5'd0, 32'h5678, 32'h0, 1'b1, 5'd3, 5'd3, 5'd1, 32'h5678, 32'h0, 32'h1234, 2'b00, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h5678, 32'h5678, 32'h5678, 2'b11, 1'b1, 32'h8, 1'b0};
    vecs[12] = '{2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h8, 1'b0};
    vecs[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0, 32'h5678, 32'h0, 2'b10, 1'b0, 32'h8, 1'b0};
    vecs[14] = '{2'b11, 5'd3, 5'd9, 32'hAAAA, 32'h99, 1'b1, 5'd9, 5'd3, 5'd9, 32'hAAAA, 32'h99, 32'h5678, 2'b00, 1'b1, 32'h8, 1'b0};
    vecs[15] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'hAAAA, 32'h99, 32'hAAAA, 2'b10, 1'b0, 32'h200, 1'b0};

    rst_n = 1'b0;
    idle();
    rd_addr = '0;
    #1;
    check("reset busy_vec", busy_vec, 32'h0);
    check("reset wr_conflict", 32'(wr_conflict), 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      check($sformatf("reset x%0d data", a), rd_data[31:0] | rd_data[63:32] | rd_data_nb[31:0], 32'h0);
      check($sformatf("reset x%0d busy", a), 32'({rd_busy, rd_busy_nb}), 32'h0);
    end
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wr_en = vecs[i].we;
      wr_addr = {vecs[i].wa1, vecs[i].wa0};
      wr_data = {vecs[i].wd1, vecs[i].wd0};
      alloc_en = vecs[i].ae;
      alloc_addr = vecs[i].aa;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #3;
      check($sformatf("v%0d rd_data0", i), rd_data[31:0], vecs[i].d0);
      check($sformatf("v%0d rd_data1", i), rd_data[63:32], vecs[i].d1);
      check($sformatf("v%0d nb rd_data0", i), rd_data_nb[31:0], vecs[i].nb0);
      check($sformatf("v%0d rd_busy", i), 32'(rd_busy), 32'(vecs[i].rb));
      check($sformatf("v%0d nb rd_busy0", i), 32'(rd_busy_nb[0]), 32'(vecs[i].nbb));
      check($sformatf("v%0d busy_vec", i), busy_vec, vecs[i].bv);
      check($sformatf("v%0d nb busy_vec", i), busy_vec_nb, vecs[i].bv);
      check($sformatf("v%0d wr_conflict", i), 32'({wr_conflict, wr_conflict_nb}), vecs[i].cf ? 32'h3 : 32'h0);
      tick();
    end

    for (int r = 1; r < 32; r++) begin
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'(r)};
      wr_data = {32'h0, 32'(r) * 32'h01010101};
      alloc_en = 1'b1;
      alloc_addr = 5'(r);
      tick();
    end
    idle();
    rd_addr = {5'd31, 5'd17};
    #1;
    check("fill x17", rd_data[31:0], 32'h11111111);
    check("fill x31", rd_data[63:32], 32'h1F1F1F1F);
    check("fill busy_vec", busy_vec, 32'hFFFFFFFE);
    check("fill rd_busy", 32'(rd_busy), 32'h3);
    rst_n = 1'b0;
    #1;
    check("async rst busy_vec", busy_vec, 32'h0);
    check("async rst x17/x31", rd_data[31:0] | rd_data[63:32], 32'h0);
    check("async rst rd_busy", 32'(rd_busy), 32'h0);
    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #0.2;
      check($sformatf("async rst x%0d", a), rd_data[31:0] | rd_data_nb[63:32], 32'h0);
    end

    tick();
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd4};
    wr_data = {32'h0, 32'hCAFE};
    alloc_en = 1'b1;
    alloc_addr = 5'd6;
    rd_addr = {5'd6, 5'd4};
    #3;
    check("rst bypass x4", rd_data[31:0], 32'hCAFE);
    check("rst nb x4", rd_data_nb[31:0], 32'h0);
    check("rst rd_busy", 32'({rd_busy, rd_busy_nb}), 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    #3;
    check("post rst x4 discarded", rd_data[31:0], 32'h0);
    check("post rst busy_vec", busy_vec, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
